// File: rtl/tank_pkg.sv
// Shared tank-game types: direction and hit-state encodings, playfield size, coordinate payload.
package tank_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;
    localparam int unsigned COORD_W  = 10;
    localparam int unsigned ARITH_W  = 11;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'b000,
        DIR_UP    = 3'b001,
        DIR_RIGHT = 3'b010,
        DIR_LEFT  = 3'b011,
        DIR_DOWN  = 3'b100
    } dir_t;

    typedef enum logic [1:0] {
        HIT_IDLE = 2'b00,
        HIT_FLY  = 2'b01,
        HIT_WALL = 2'b10,
        HIT_TANK = 2'b11
    } hit_t;

    typedef struct packed {
        logic [ARITH_W-1:0] x;
        logic [ARITH_W-1:0] y;
    } pos_t;

    function automatic dir_t reverse_dir(input dir_t d);
        case (d)
            DIR_UP:    return DIR_DOWN;
            DIR_DOWN:  return DIR_UP;
            DIR_LEFT:  return DIR_RIGHT;
            DIR_RIGHT: return DIR_LEFT;
            default:   return d;
        endcase
    endfunction

endpackage

// File: rtl/aabb_overlap.sv
// Strict axis-aligned box overlap test; sums wrap at W bits.
module aabb_overlap #(
    parameter int unsigned W = 11
) (
    input  logic [W-1:0] ax,
    input  logic [W-1:0] ay,
    input  logic [W-1:0] aw,
    input  logic [W-1:0] ah,
    input  logic [W-1:0] bx,
    input  logic [W-1:0] by,
    input  logic [W-1:0] bw,
    input  logic [W-1:0] bh,
    output logic         overlap
);

    assign overlap = (ax < bx + bw) && (bx < ax + aw) &&
                     (ay < by + bh) && (by < ay + ah);

endmodule

// File: rtl/bullet_controller.sv
// Per-tank projectile engine: spawn on fire, advance per frame tick, collide with enemy/walls/edges.
// Define BULLET_BOUNCE_EN to make the first edge contact reverse direction instead of ending the flight.
module bullet_controller
    import tank_pkg::*;
#(
    parameter int unsigned SPEED     = 4,
    parameter int unsigned BULLET_SZ = 8,
    parameter int unsigned TANK_SZ   = 32,
    parameter int unsigned COOLDOWN  = 15,
    parameter int unsigned WALL_H_W  = 64,
    parameter int unsigned WALL_H_H  = 32,
    parameter int unsigned WALL_V_W  = 32,
    parameter int unsigned WALL_V_H  = 64
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         frame_clk,
    input  logic         fire,
    input  logic         own_alive,
    input  logic [2:0]   tank_dir,
    input  logic [9:0]   tankX,
    input  logic [9:0]   tankY,
    input  logic [9:0]   enemyX,
    input  logic [9:0]   enemyY,
    input  logic         enemy_alive,
    input  logic [9:0]   wallX1,
    input  logic [9:0]   wallX2,
    input  logic [9:0]   wallX3,
    input  logic [9:0]   wallX4,
    input  logic [9:0]   wallY1,
    input  logic [9:0]   wallY2,
    input  logic [9:0]   wallY3,
    input  logic [9:0]   wallY4,
    input  logic [3:0]   wall_alive,
    input  logic [9:0]   DrawX,
    input  logic [9:0]   DrawY,
    output logic [9:0]   bulletX,
    output logic [9:0]   bulletY,
    output logic         is_bullet,
    output logic [1:0]   hit,
    output logic [3:0]   wall_hit,
    output logic         tank_kill
);

    localparam int unsigned AW      = ARITH_W;
    localparam int unsigned CNT_W   = $clog2(COOLDOWN + 1);
    localparam int unsigned OFS     = (TANK_SZ - BULLET_SZ) / 2;
    localparam logic [AW-1:0] SPD   = AW'(SPEED);
    localparam logic [AW-1:0] BSZ   = AW'(BULLET_SZ);
    localparam logic [AW-1:0] SW    = AW'(SCREEN_W);
    localparam logic [AW-1:0] SH    = AW'(SCREEN_H);

    hit_t              state_q, state_d;
    dir_t              dir_q, dir_d;
    logic [9:0]        pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [CNT_W-1:0]  cool_q, cool_d;
    logic              frame_d, fire_d;
    logic [3:0]        wall_hit_q, wall_hit_d;
    logic              tank_kill_q, tank_kill_d;
`ifdef BULLET_BOUNCE_EN
    logic              bounced_q, bounced_d;
`endif

    logic              tick, fire_ev, spawn_ok, off_screen, enemy_ov;
    logic [AW-1:0]     tx, ty, cx, cy;
    pos_t              spawn, next_pos;
    logic [3:0][AW-1:0] wall_x, wall_y;
    logic [3:0]        wall_ov, wall_sel;

    assign tick    = frame_clk & ~frame_d;
    assign fire_ev = fire & ~fire_d;
    assign tx      = AW'(tankX);
    assign ty      = AW'(tankY);
    assign cx      = AW'(pos_x_q);
    assign cy      = AW'(pos_y_q);
    assign wall_x  = {AW'(wallX4), AW'(wallX3), AW'(wallX2), AW'(wallX1)};
    assign wall_y  = {AW'(wallY4), AW'(wallY3), AW'(wallY2), AW'(wallY1)};

    // Muzzle position for the requested direction; rejected if any part lands off-screen
    always_comb begin
        spawn    = '0;
        spawn_ok = 1'b0;
        case (dir_t'(tank_dir))
            DIR_UP:    begin spawn.x = tx + AW'(OFS); spawn.y = ty - BSZ; spawn_ok = (ty >= BSZ); end
            DIR_DOWN:  begin spawn.x = tx + AW'(OFS); spawn.y = ty + AW'(TANK_SZ); spawn_ok = 1'b1; end
            DIR_RIGHT: begin spawn.x = tx + AW'(TANK_SZ); spawn.y = ty + AW'(OFS); spawn_ok = 1'b1; end
            DIR_LEFT:  begin spawn.x = tx - BSZ; spawn.y = ty + AW'(OFS); spawn_ok = (tx >= BSZ); end
            default:   spawn_ok = 1'b0;
        endcase
        if ((spawn.x + BSZ > SW) || (spawn.y + BSZ > SH))
            spawn_ok = 1'b0;
    end

    // Candidate position one step along the latched direction, plus edge test on the current one
    always_comb begin
        next_pos   = '{x: cx, y: cy};
        off_screen = 1'b0;
        case (dir_q)
            DIR_UP:    begin next_pos.y = cy - SPD; off_screen = (cy < SPD); end
            DIR_DOWN:  begin next_pos.y = cy + SPD; off_screen = (cy + BSZ + SPD > SH); end
            DIR_LEFT:  begin next_pos.x = cx - SPD; off_screen = (cx < SPD); end
            DIR_RIGHT: begin next_pos.x = cx + SPD; off_screen = (cx + BSZ + SPD > SW); end
            default:   off_screen = 1'b0;
        endcase
    end

    aabb_overlap #(.W(AW)) u_enemy_ov (
        .ax(next_pos.x), .ay(next_pos.y), .aw(BSZ), .ah(BSZ),
        .bx(AW'(enemyX)), .by(AW'(enemyY)), .bw(AW'(TANK_SZ)), .bh(AW'(TANK_SZ)),
        .overlap(enemy_ov)
    );

    for (genvar k = 0; k < 4; k++) begin : g_wall
        localparam int unsigned WW = (k % 2 == 0) ? WALL_H_W : WALL_V_W;
        localparam int unsigned WH = (k % 2 == 0) ? WALL_H_H : WALL_V_H;
        aabb_overlap #(.W(AW)) u_wall_ov (
            .ax(next_pos.x), .ay(next_pos.y), .aw(BSZ), .ah(BSZ),
            .bx(wall_x[k]), .by(wall_y[k]), .bw(AW'(WW)), .bh(AW'(WH)),
            .overlap(wall_ov[k])
        );
    end

    // Lowest-index live wall wins so at most one damage pulse fires
    always_comb begin
        wall_sel = '0;
        for (int k = 3; k >= 0; k--) begin
            if (wall_ov[k] && wall_alive[k]) begin
                wall_sel    = '0;
                wall_sel[k] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        cool_d      = cool_q;
        wall_hit_d  = '0;
        tank_kill_d = 1'b0;
`ifdef BULLET_BOUNCE_EN
        bounced_d   = bounced_q;
`endif
        if (!own_alive) begin
            state_d = HIT_IDLE;
            cool_d  = '0;
        end else begin
            case (state_q)
                HIT_IDLE: begin
                    if (fire_ev && spawn_ok) begin
                        state_d = HIT_FLY;
                        dir_d   = dir_t'(tank_dir);
                        pos_x_d = spawn.x[9:0];
                        pos_y_d = spawn.y[9:0];
`ifdef BULLET_BOUNCE_EN
                        bounced_d = 1'b0;
`endif
                    end
                end
                HIT_FLY: begin
                    if (tick) begin
                        if (enemy_alive && enemy_ov) begin
                            state_d     = HIT_TANK;
                            tank_kill_d = 1'b1;
                            cool_d      = '0;
                        end else if (|wall_sel) begin
                            state_d    = HIT_WALL;
                            wall_hit_d = wall_sel;
                            cool_d     = '0;
                        end else if (off_screen) begin
`ifdef BULLET_BOUNCE_EN
                            if (!bounced_q) begin
                                dir_d     = reverse_dir(dir_q);
                                bounced_d = 1'b1;
                            end else begin
                                state_d = HIT_IDLE;
                            end
`else
                            state_d = HIT_IDLE;
`endif
                        end else begin
                            pos_x_d = next_pos.x[9:0];
                            pos_y_d = next_pos.y[9:0];
                        end
                    end
                end
                HIT_WALL, HIT_TANK: begin
                    if (tick) begin
                        if (cool_q == CNT_W'(COOLDOWN - 1)) begin
                            state_d = HIT_IDLE;
                            cool_d  = '0;
                        end else begin
                            cool_d = cool_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = HIT_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= HIT_IDLE;
            dir_q       <= DIR_NONE;
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            cool_q      <= '0;
            frame_d     <= 1'b0;
            fire_d      <= 1'b0;
            wall_hit_q  <= '0;
            tank_kill_q <= 1'b0;
`ifdef BULLET_BOUNCE_EN
            bounced_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            cool_q      <= cool_d;
            frame_d     <= frame_clk;
            fire_d      <= fire;
            wall_hit_q  <= wall_hit_d;
            tank_kill_q <= tank_kill_d;
`ifdef BULLET_BOUNCE_EN
            bounced_q   <= bounced_d;
`endif
        end
    end

    assign bulletX   = pos_x_q;
    assign bulletY   = pos_y_q;
    assign hit       = state_q;
    assign wall_hit  = wall_hit_q;
    assign tank_kill = tank_kill_q;
    assign is_bullet = (state_q == HIT_FLY) &&
                       (DrawX >= pos_x_q) && (AW'(DrawX) < cx + BSZ) &&
                       (DrawY >= pos_y_q) && (AW'(DrawY) < cy + BSZ);

endmodule

// File: tb/tb_bullet_controller.sv
// Directed bench for bullet_controller: spawn/flight vector table plus wall, tank, exit and reset sequences.
module tb_bullet_controller;

    logic       Clk = 1'b0;
    logic       Reset_n, frame_clk, fire, own_alive, enemy_alive;
    logic [2:0] tank_dir;
    logic [9:0] tankX, tankY, enemyX, enemyY, DrawX, DrawY;
    logic [9:0] wallX1, wallX2, wallX3, wallX4, wallY1, wallY2, wallY3, wallY4;
    logic [3:0] wall_alive, wall_hit;
    logic [9:0] bulletX, bulletY;
    logic       is_bullet, tank_kill;
    logic [1:0] hit;

    int checks = 0;
    int failures = 0;
    int wh_cnt = 0;
    int tk_cnt = 0;
    logic [3:0] wh_last = 4'b0000;

`ifdef BULLET_BOUNCE_EN
    localparam logic [1:0] OFF_HIT = 2'b01;
    localparam int EXIT_TICKS = 193;
    localparam int EXIT_Y = 472;
`else
    localparam logic [1:0] OFF_HIT = 2'b00;
    localparam int EXIT_TICKS = 74;
    localparam int EXIT_Y = 0;
`endif

    bullet_controller dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .fire(fire),
        .own_alive(own_alive), .tank_dir(tank_dir), .tankX(tankX), .tankY(tankY),
        .enemyX(enemyX), .enemyY(enemyY), .enemy_alive(enemy_alive),
        .wallX1(wallX1), .wallX2(wallX2), .wallX3(wallX3), .wallX4(wallX4),
        .wallY1(wallY1), .wallY2(wallY2), .wallY3(wallY3), .wallY4(wallY4),
        .wall_alive(wall_alive), .DrawX(DrawX), .DrawY(DrawY),
        .bulletX(bulletX), .bulletY(bulletY), .is_bullet(is_bullet), .hit(hit),
        .wall_hit(wall_hit), .tank_kill(tank_kill)
    );

    always #5 Clk = ~Clk;

    // Pulse monitor: counts and remembers damage/kill pulses
    always @(negedge Clk) begin
        if (wall_hit != 4'b0000) begin
            wh_cnt  <= wh_cnt + 1;
            wh_last <= wall_hit;
        end
        if (tank_kill) tk_cnt <= tk_cnt + 1;
    end

    typedef struct {
        logic [9:0] tx;
        logic [9:0] ty;
        logic [2:0] dir;
        logic       alive;
        int         ticks;
        logic [9:0] ex;
        logic [9:0] ey;
        logic [1:0] eh;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        fire = 1'b0;
        frame_clk = 1'b0;
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic tick();
        frame_clk = 1'b1;
        @(negedge Clk);
        frame_clk = 1'b0;
        @(negedge Clk);
    endtask

    task automatic fire_once();
        fire = 1'b1;
        @(negedge Clk);
        fire = 1'b0;
    endtask

    initial begin
        int n;
        int k0;
        Reset_n = 1'b0; frame_clk = 1'b0; fire = 1'b0; own_alive = 1'b1;
        tank_dir = 3'b010; tankX = '0; tankY = '0;
        enemyX = 10'd300; enemyY = 10'd40; enemy_alive = 1'b0;
        wallX1 = 10'd104; wallY1 = 10'd200; wallX2 = 10'd400; wallY2 = 10'd400;
        wallX3 = 10'd104; wallY3 = 10'd200; wallX4 = 10'd500; wallY4 = 10'd400;
        wall_alive = 4'b0000; DrawX = '0; DrawY = '0;

        vecs[0]  = '{10'd200, 10'd200, 3'b010, 1'b1, 0, 10'd232, 10'd212, 2'b01};
        vecs[1]  = '{10'd200, 10'd200, 3'b010, 1'b1, 3, 10'd244, 10'd212, 2'b01};
        vecs[2]  = '{10'd100, 10'd300, 3'b001, 1'b1, 0, 10'd112, 10'd292, 2'b01};
        vecs[3]  = '{10'd100, 10'd300, 3'b100, 1'b1, 2, 10'd112, 10'd340, 2'b01};
        vecs[4]  = '{10'd100, 10'd300, 3'b011, 1'b1, 1, 10'd88,  10'd312, 2'b01};
        vecs[5]  = '{10'd100, 10'd4,   3'b001, 1'b1, 0, 10'd0,   10'd0,   2'b00};
        vecs[6]  = '{10'd4,   10'd100, 3'b011, 1'b1, 0, 10'd0,   10'd0,   2'b00};
        vecs[7]  = '{10'd620, 10'd100, 3'b010, 1'b1, 0, 10'd0,   10'd0,   2'b00};
        vecs[8]  = '{10'd600, 10'd100, 3'b010, 1'b1, 1, 10'd632, 10'd112, OFF_HIT};
        vecs[9]  = '{10'd100, 10'd440, 3'b100, 1'b1, 1, 10'd112, 10'd472, OFF_HIT};
        vecs[10] = '{10'd100, 10'd300, 3'b000, 1'b1, 0, 10'd0,   10'd0,   2'b00};
        vecs[11] = '{10'd200, 10'd200, 3'b010, 1'b0, 0, 10'd0,   10'd0,   2'b00};
        vecs[12] = '{10'd100, 10'd8,   3'b001, 1'b1, 0, 10'd112, 10'd0,   2'b01};

        do_reset();
        check("rst_hit", 32'(hit), 0);
        check("rst_x", 32'(bulletX), 0);
        check("rst_y", 32'(bulletY), 0);
        check("rst_pulses", 32'({wall_hit, tank_kill}), 0);

        // Spawn / flight table; fire stays held through the ticks so a refire would show up
        for (int i = 0; i < NV; i++) begin
            do_reset();
            tankX = vecs[i].tx; tankY = vecs[i].ty;
            tank_dir = vecs[i].dir; own_alive = vecs[i].alive;
            fire = 1'b1;
            @(negedge Clk);
            for (int t = 0; t < vecs[i].ticks; t++) tick();
            check($sformatf("v%0d_hit", i), 32'(hit), 32'(vecs[i].eh));
            check($sformatf("v%0d_x", i), 32'(bulletX), 32'(vecs[i].ex));
            check($sformatf("v%0d_y", i), 32'(bulletY), 32'(vecs[i].ey));
            DrawX = vecs[i].ex + 10'd7;
            DrawY = vecs[i].ey + 10'd7;
            #1;
            check($sformatf("v%0d_isb", i), 32'(is_bullet), 32'(vecs[i].eh == 2'b01));
            fire = 1'b0;
            own_alive = 1'b1;
        end

        // Mid-flight asynchronous reset
        do_reset();
        tankX = 10'd68; tankY = 10'd88; tank_dir = 3'b010;
        fire_once();
        check("mid_fly_x", 32'(bulletX), 100);
        check("mid_fly_y", 32'(bulletY), 100);
        DrawX = 10'd100; DrawY = 10'd100;
        #1;
        check("mid_isb_in", 32'(is_bullet), 1);
        DrawX = 10'd108;
        #1;
        check("mid_isb_edge", 32'(is_bullet), 0);
        DrawX = 10'd100;
        Reset_n = 1'b0;
        #1;
        check("mid_rst_hit", 32'(hit), 0);
        check("mid_rst_xy", 32'({bulletX, bulletY}), 0);
        check("mid_rst_isb", 32'(is_bullet), 0);
        check("mid_rst_pulses", 32'({wall_hit, tank_kill}), 0);

        // Wall strike: wall1 and wall3 overlap, wall1 must win
        do_reset();
        tankX = 10'd100; tankY = 10'd300; tank_dir = 3'b001;
        wall_alive = 4'b0101; enemy_alive = 1'b0;
        fire_once();
        k0 = wh_cnt;
        n = 0;
        for (int i = 1; i <= 30 && n == 0; i++) begin
            tick();
            if (hit != 2'b01) n = i;
        end
        check("wall_tick", n, 16);
        check("wall_state", 32'(hit), 2);
        check("wall_pos_x", 32'(bulletX), 112);
        check("wall_pos_y", 32'(bulletY), 232);
        check("wall_pulse_cnt", wh_cnt - k0, 1);
        check("wall_pulse_val", 32'(wh_last), 1);
        DrawX = 10'd112; DrawY = 10'd232;
        #1;
        check("wall_isb", 32'(is_bullet), 0);
        repeat (5) tick();
        fire_once();
        @(negedge Clk);
        check("wall_fire_ign", 32'(hit), 2);
        repeat (9) tick();
        check("wall_cool_14", 32'(hit), 2);
        tick();
        check("wall_cool_15", 32'(hit), 0);

        // Enemy strike, then own tank dies during cooldown
        do_reset();
        wall_alive = 4'b0000;
        enemyX = 10'd100; enemyY = 10'd150; enemy_alive = 1'b1;
        fire_once();
        k0 = tk_cnt;
        n = 0;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            tick();
            if (hit != 2'b01) n = i;
        end
        check("tank_tick", n, 28);
        check("tank_state", 32'(hit), 3);
        check("tank_pos_y", 32'(bulletY), 184);
        check("tank_pulse_cnt", tk_cnt - k0, 1);
        own_alive = 1'b0;
        @(negedge Clk);
        check("own_dead_idle", 32'(hit), 0);
        own_alive = 1'b1;

        // Dead enemy: bullet passes through and leaves the top edge
        do_reset();
        enemy_alive = 1'b0;
        fire_once();
        k0 = tk_cnt;
        n = 0;
        for (int i = 1; i <= 250 && n == 0; i++) begin
            tick();
            if (hit != 2'b01) n = i;
        end
        check("exit_tick", n, EXIT_TICKS);
        check("exit_state", 32'(hit), 0);
        check("exit_pos_y", 32'(bulletY), EXIT_Y);
        check("exit_no_kill", tk_cnt - k0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
